// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, debug) and the memory.
// slave = arbiter view; master = requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_mode;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [2:0]        dbg_mode;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              owner;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_mode, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    output owner, mem_read, mem_write, mem_mode, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_mode, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    input  owner, mem_read, mem_write, mem_mode, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/debug arbiter for the single-ported data memory; write acks 2 cycles after req, read 2+MEM_LAT.
// Requests are held until ack; the CPU stalls while its access is outstanding, the loser waits in IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              grant_dbg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
      we_q    <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    we_d      = we_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    // ptr_q = 1 means debug was granted last, so the CPU wins a tie
    grant_dbg = bus.dbg_req & (~bus.cpu_req | ~ptr_q);

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req | bus.dbg_req) begin
          owner_d = grant_dbg;
          ptr_d   = grant_dbg;
          we_d    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
          mode_d  = grant_dbg ? bus.dbg_mode  : bus.cpu_mode;
          addr_d  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
          wdata_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 3'(MEM_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and acks decode straight from state so an async reset kills them at once
  assign bus.mem_read  = (state_q == S_ISSUE) & ~we_q;
  assign bus.mem_write = (state_q == S_ISSUE) & we_q;
  assign bus.mem_mode  = mode_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_ack   = (state_q == S_RESP) & ~owner_q;
  assign bus.dbg_ack   = (state_q == S_RESP) & owner_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.dbg_rdata = rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2; cycle 0 is the first cycle a request is seen in IDLE.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vec = 0;
  int   err = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_mode = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_mode = '0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    ctl = {bus.cpu_ack, bus.dbg_ack, bus.mem_read, bus.mem_write, bus.owner, bus.cpu_stall, bus.mem_mode == 3'd0};
    vec++;
    if (ctl !== 7'b0000001) begin
      err++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0000001);
    end
    vec++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata} !== 128'd0) begin
      err++; $display("FAIL reset_data: got %h %h %h %h expected all zero",
                      bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_store();
    logic [3:0] got, exp;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_mode = 3'b010;
    bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      #1;
      got = {bus.mem_write, bus.mem_read, bus.cpu_ack, bus.cpu_stall};
      exp = {c == 1, 1'b0, c == 2, c <= 1};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL store_c%0d wr/rd/ack/stall: got %b expected %b", c, got, exp);
      end
      if (c >= 1) begin
        vec++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_mode, bus.owner} !== {32'h10, 32'hDEADBEEF, 3'b010, 1'b0}) begin
          err++; $display("FAIL store_c%0d latched: got %h %h %b %b expected 10 deadbeef 010 0",
                          c, bus.mem_addr, bus.mem_wdata, bus.mem_mode, bus.owner);
        end
      end
      if (c == 2) bus.cpu_req = 1'b0;
      tick();
    end
    vec++;
    if (bus.cpu_rdata !== 32'h0) begin
      err++; $display("FAIL store_rdata_unchanged: got %h expected 00000000", bus.cpu_rdata);
    end
  endtask

  task automatic test_dbg_load();
    logic [3:0] got, exp;
    bus.mem_rdata = 32'h12345678;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_mode = 3'b100; bus.dbg_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      #1;
      got = {bus.mem_read, bus.mem_write, bus.dbg_ack, bus.cpu_ack};
      exp = {c == 1, 1'b0, c == 4, 1'b0};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL dbgld_c%0d rd/wr/dack/cack: got %b expected %b", c, got, exp);
      end
      if (c >= 4) begin
        vec++;
        if ({bus.dbg_rdata, bus.cpu_rdata, bus.owner, bus.mem_addr} !== {32'h12345678, 32'h12345678, 1'b1, 32'h20}) begin
          err++; $display("FAIL dbgld_c%0d data: got %h %h %b %h expected 12345678 12345678 1 20",
                          c, bus.dbg_rdata, bus.cpu_rdata, bus.owner, bus.mem_addr);
        end
      end
      if (c == 4) bus.dbg_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_tie();
    logic [3:0] got, exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'h1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h200; bus.dbg_wdata = 32'h2;
    for (int c = 0; c < 10; c++) begin
      #1;
      got = {bus.cpu_ack, bus.dbg_ack, bus.owner, bus.mem_write};
      exp = {c == 2 || c == 8, c == 5, c >= 4 && c <= 6, c == 1 || c == 4 || c == 7};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL tie_c%0d cack/dack/owner/wr: got %b expected %b", c, got, exp);
      end
      if (c == 4) begin
        vec++;
        if (bus.mem_addr !== 32'h200) begin
          err++; $display("FAIL tie_dbg_addr: got %h expected 00000200", bus.mem_addr);
        end
      end
      if (c == 8) begin bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got, exp;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    for (int c = 0; c < 15; c++) begin
      bus.mem_rdata = 32'hA0000000 | 32'(c);
      #1;
      got = {bus.mem_read, bus.cpu_ack};
      exp = {c % 5 == 1, c % 5 == 4};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL b2b_c%0d rd/ack: got %b expected %b", c, got, exp);
      end
      if (c % 5 == 4) begin
        vec++;
        if (bus.cpu_rdata !== (32'hA0000000 | 32'(c - 1))) begin
          err++; $display("FAIL b2b_c%0d rdata: got %h expected %h", c, bus.cpu_rdata, 32'hA0000000 | 32'(c - 1));
        end
      end
      if (c == 14) bus.cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    bus.mem_rdata = 32'hCAFEF00D;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h80;
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    got = {bus.cpu_ack, bus.dbg_ack, bus.mem_read, bus.mem_write, bus.owner};
    vec++;
    if (got !== 5'b0 || bus.mem_addr !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
      err++; $display("FAIL rstmid_clear: got %b %h %h expected 00000 00000000 00000000", got, bus.mem_addr, bus.cpu_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (bus.cpu_ack !== 1'b0) begin
        err++; $display("FAIL rstmid_noack_%0d: got %b expected 0", i, bus.cpu_ack);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vec++;
      if ({bus.mem_read, bus.cpu_ack} !== {c == 1, c == 4}) begin
        err++; $display("FAIL rstmid_c%0d rd/ack: got %b%b expected %b%b", c, bus.mem_read, bus.cpu_ack, c == 1, c == 4);
      end
      if (c == 4) begin
        vec++;
        if (bus.cpu_rdata !== 32'hCAFEF00D) begin
          err++; $display("FAIL rstmid_rdata: got %h expected cafef00d", bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_drop_in_wait();
    logic [2:0] got, exp;
    bus.mem_rdata = 32'h55AA55AA;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h90;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) bus.dbg_req = 1'b0;
      #1;
      got = {bus.mem_read, bus.dbg_ack, bus.cpu_ack};
      exp = {c == 1, c == 4, 1'b0};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL drop_c%0d rd/dack/cack: got %b expected %b", c, got, exp);
      end
      if (c == 4) begin
        vec++;
        if (bus.dbg_rdata !== 32'h55AA55AA) begin
          err++; $display("FAIL drop_rdata: got %h expected 55aa55aa", bus.dbg_rdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cpu_store();
    test_dbg_load();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_drop_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
